// File: rtl/cpu_request_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cpu_request_sequencer
// Brief    : Replays a programmable table of read/write requests into a
//            cache CPU port, one entry per hit_miss completion. Provides
//            start/done control, per-request timeout and stall statistics.
//            Optional macro CHECK_READ_DATA_EN adds per-entry expected read
//            data and a read-data mismatch counter.
// Revision : 1.0  initial release
// ============================================================================
module cpu_request_sequencer #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int IDX_WIDTH  = $clog2(DEPTH),
    parameter int TIMEOUT    = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [IDX_WIDTH:0]    num_req,
    input  logic                  prog_we,
    input  logic [IDX_WIDTH-1:0]  prog_idx,
    input  logic                  prog_rw,
    input  logic [ADDR_WIDTH-1:0] prog_addr,
    input  logic [DATA_WIDTH-1:0] prog_wdata,
    input  logic [DATA_WIDTH-1:0] prog_expect,
    input  logic                  hit_miss,
    input  logic [DATA_WIDTH-1:0] read_data,
    output logic                  req_valid,
    output logic                  read_write,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] write_data,
    output logic [IDX_WIDTH-1:0]  req_index,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout,
    output logic [15:0]           stall_cycles,
    output logic [IDX_WIDTH:0]    mismatch_count
);

    localparam logic [1:0]         c_IDLE    = 2'd0;
    localparam logic [1:0]         c_ISSUE   = 2'd1;
    localparam logic [1:0]         c_DONE    = 2'd2;
    localparam logic [IDX_WIDTH:0] c_DEPTH   = (IDX_WIDTH+1)'(DEPTH);
    localparam logic [15:0]        c_TO_LAST = 16'(TIMEOUT - 1);

    logic [1:0]            r_state;
    logic                  r_req_valid;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_timeout;
    logic [IDX_WIDTH-1:0]  r_req_index;
    logic [IDX_WIDTH:0]    r_count;
    logic [15:0]           r_stall_cycles;
    logic [15:0]           r_req_stall;

    logic                  r_tab_rw    [DEPTH];
    logic [ADDR_WIDTH-1:0] r_tab_addr  [DEPTH];
    logic [DATA_WIDTH-1:0] r_tab_wdata [DEPTH];

    logic                  w_prog_ok;
    logic [IDX_WIDTH:0]    w_count;
    logic                  w_last;

    // Table is only writable while no run is in flight.
    assign w_prog_ok = prog_we && (r_state != c_ISSUE);
    // Requests beyond the table size are clamped to a full-table replay.
    assign w_count   = (num_req > c_DEPTH) ? c_DEPTH : num_req;
    assign w_last    = ({1'b0, r_req_index} == (r_count - 1'b1));

`ifdef CHECK_READ_DATA_EN
    logic [DATA_WIDTH-1:0] r_tab_expect [DEPTH];
    logic [IDX_WIDTH:0]    r_mismatch_count;
    logic                  w_rd_miss;

    // A completing read whose data differs from the programmed expectation.
    assign w_rd_miss      = !r_tab_rw[r_req_index] &&
                            (read_data != r_tab_expect[r_req_index]);
    assign mismatch_count = r_mismatch_count;

    // Expected-data storage, written alongside the rest of the entry.
    always_ff @(posedge clock) begin
        if (w_prog_ok) begin
            r_tab_expect[prog_idx] <= prog_expect;
        end
    end
`else
    logic w_unused;

    assign w_unused       = ^{prog_expect, read_data};
    assign mismatch_count = '0;
`endif

    // Request table write port; contents intentionally survive reset.
    always_ff @(posedge clock) begin
        if (w_prog_ok) begin
            r_tab_rw[prog_idx]    <= prog_rw;
            r_tab_addr[prog_idx]  <= prog_addr;
            r_tab_wdata[prog_idx] <= prog_wdata;
        end
    end

    // Run control FSM with registered status outputs and statistics.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state          <= c_IDLE;
            r_req_valid      <= 1'b0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_timeout        <= 1'b0;
            r_req_index      <= '0;
            r_count          <= '0;
            r_stall_cycles   <= '0;
            r_req_stall      <= '0;
`ifdef CHECK_READ_DATA_EN
            r_mismatch_count <= '0;
`endif
        end else begin
            case (r_state)
                c_IDLE, c_DONE: begin
                    if (start) begin
                        r_count          <= w_count;
                        r_req_index      <= '0;
                        r_stall_cycles   <= '0;
                        r_req_stall      <= '0;
                        r_timeout        <= 1'b0;
`ifdef CHECK_READ_DATA_EN
                        r_mismatch_count <= '0;
`endif
                        if (w_count == '0) begin
                            r_state     <= c_DONE;
                            r_done      <= 1'b1;
                            r_busy      <= 1'b0;
                            r_req_valid <= 1'b0;
                        end else begin
                            r_state     <= c_ISSUE;
                            r_done      <= 1'b0;
                            r_busy      <= 1'b1;
                            r_req_valid <= 1'b1;
                        end
                    end
                end
                c_ISSUE: begin
                    if (hit_miss) begin
                        r_req_stall <= '0;
`ifdef CHECK_READ_DATA_EN
                        if (w_rd_miss && (r_mismatch_count != '1)) begin
                            r_mismatch_count <= r_mismatch_count + 1'b1;
                        end
`endif
                        if (w_last) begin
                            r_state     <= c_DONE;
                            r_done      <= 1'b1;
                            r_busy      <= 1'b0;
                            r_req_valid <= 1'b0;
                        end else begin
                            r_req_index <= r_req_index + 1'b1;
                        end
                    end else begin
                        if (r_stall_cycles != 16'hFFFF) begin
                            r_stall_cycles <= r_stall_cycles + 16'd1;
                        end
                        if (r_req_stall != 16'hFFFF) begin
                            r_req_stall <= r_req_stall + 16'd1;
                        end
                        if ((TIMEOUT > 0) && (r_req_stall == c_TO_LAST)) begin
                            r_state     <= c_DONE;
                            r_done      <= 1'b1;
                            r_timeout   <= 1'b1;
                            r_busy      <= 1'b0;
                            r_req_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // Request fields come straight from the table, forced to zero when idle.
    assign req_valid    = r_req_valid;
    assign read_write   = r_req_valid ? r_tab_rw[r_req_index]    : 1'b0;
    assign address      = r_req_valid ? r_tab_addr[r_req_index]  : '0;
    assign write_data   = r_req_valid ? r_tab_wdata[r_req_index] : '0;
    assign req_index    = r_req_index;
    assign busy         = r_busy;
    assign done         = r_done;
    assign timeout      = r_timeout;
    assign stall_cycles = r_stall_cycles;

endmodule
`default_nettype wire

// File: tb/tb_cpu_request_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_request_sequencer
// Brief    : Directed self-checking bench for cpu_request_sequencer.
//            Expected mismatch_count follows CHECK_READ_DATA_EN.
// Revision : 1.0  initial release
// ============================================================================
module tb_cpu_request_sequencer;

    localparam int c_AW = 10;
    localparam int c_DW = 32;
    localparam int c_DEPTH = 16;
    localparam int c_IW = 4;

    logic            clock = 1'b0;
    logic            reset;
    logic            start;
    logic [c_IW:0]   num_req;
    logic            prog_we;
    logic [c_IW-1:0] prog_idx;
    logic            prog_rw;
    logic [c_AW-1:0] prog_addr;
    logic [c_DW-1:0] prog_wdata;
    logic [c_DW-1:0] prog_expect;
    logic            hit_miss;
    logic [c_DW-1:0] read_data;
    logic            req_valid;
    logic            read_write;
    logic [c_AW-1:0] address;
    logic [c_DW-1:0] write_data;
    logic [c_IW-1:0] req_index;
    logic            busy;
    logic            done;
    logic            timeout;
    logic [15:0]     stall_cycles;
    logic [c_IW:0]   mismatch_count;

    int n_cmp = 0;
    int n_err = 0;

    logic            t_rw   [5];
    logic [c_AW-1:0] t_addr [5];
    logic [c_DW-1:0] t_wd   [5];
    logic [c_DW-1:0] t_exp  [5];
    logic [c_IW:0]   exp_mm;

    cpu_request_sequencer #(
        .ADDR_WIDTH (c_AW),
        .DATA_WIDTH (c_DW),
        .DEPTH      (c_DEPTH),
        .IDX_WIDTH  (c_IW),
        .TIMEOUT    (8)
    ) u_dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .num_req        (num_req),
        .prog_we        (prog_we),
        .prog_idx       (prog_idx),
        .prog_rw        (prog_rw),
        .prog_addr      (prog_addr),
        .prog_wdata     (prog_wdata),
        .prog_expect    (prog_expect),
        .hit_miss       (hit_miss),
        .read_data      (read_data),
        .req_valid      (req_valid),
        .read_write     (read_write),
        .address        (address),
        .write_data     (write_data),
        .req_index      (req_index),
        .busy           (busy),
        .done           (done),
        .timeout        (timeout),
        .stall_cycles   (stall_cycles),
        .mismatch_count (mismatch_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic prog_entry(input int i);
        prog_we     = 1'b1;
        prog_idx    = c_IW'(i);
        prog_rw     = t_rw[i];
        prog_addr   = t_addr[i];
        prog_wdata  = t_wd[i];
        prog_expect = t_exp[i];
        step();
        prog_we     = 1'b0;
    endtask

    task automatic do_start(input int n);
        num_req = (c_IW+1)'(n);
        start   = 1'b1;
        step();
        start   = 1'b0;
    endtask

    task automatic chk_req(input string tag, input int k);
        chk({tag, "_valid"}, 32'(req_valid), 32'd1);
        chk({tag, "_addr"}, 32'(address), 32'(t_addr[k]));
        chk({tag, "_rw"}, 32'(read_write), 32'(t_rw[k]));
        chk({tag, "_wdata"}, write_data, t_wd[k]);
        chk({tag, "_idx"}, 32'(req_index), 32'(k));
    endtask

    initial begin
        t_rw[0] = 1'b0; t_addr[0] = 10'h1A9; t_wd[0] = 32'h0;   t_exp[0] = 32'h111;
        t_rw[1] = 1'b1; t_addr[1] = 10'h195; t_wd[1] = 32'hFAC; t_exp[1] = 32'h0;
        t_rw[2] = 1'b0; t_addr[2] = 10'h195; t_wd[2] = 32'h0;   t_exp[2] = 32'hFAC;
        t_rw[3] = 1'b0; t_addr[3] = 10'h154; t_wd[3] = 32'h0;   t_exp[3] = 32'h222;
        t_rw[4] = 1'b0; t_addr[4] = 10'h195; t_wd[4] = 32'h0;   t_exp[4] = 32'hFAC;
`ifdef CHECK_READ_DATA_EN
        exp_mm = 5'd1;
`else
        exp_mm = 5'd0;
`endif
        reset = 1'b1; start = 1'b0; num_req = '0; prog_we = 1'b0; prog_idx = '0;
        prog_rw = 1'b0; prog_addr = '0; prog_wdata = '0; prog_expect = '0;
        hit_miss = 1'b0; read_data = '0;
        step(); step();
        reset = 1'b0;

        // Reset state
        chk("rst_valid", 32'(req_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        chk("rst_addr", 32'(address), 32'd0);
        chk("rst_stall", 32'(stall_cycles), 32'd0);
        chk("rst_mm", 32'(mismatch_count), 32'd0);

        for (int i = 0; i < 5; i++) prog_entry(i);

        // Basic replay: one request per cycle
        hit_miss = 1'b1;
        do_start(5);
        for (int k = 0; k < 5; k++) begin
            chk_req("basic", k);
            chk("basic_busy", 32'(busy), 32'd1);
            read_data = t_exp[k];
            step();
        end
        chk("basic_done", 32'(done), 32'd1);
        chk("basic_valid_off", 32'(req_valid), 32'd0);
        chk("basic_addr_off", 32'(address), 32'd0);
        chk("basic_busy_off", 32'(busy), 32'd0);
        chk("basic_stall", 32'(stall_cycles), 32'd0);
        chk("basic_idx_hold", 32'(req_index), 32'd4);
        chk("basic_mm", 32'(mismatch_count), 32'd0);

        // Three stall cycles before each completion
        hit_miss = 1'b0;
        do_start(5);
        for (int k = 0; k < 5; k++) begin
            for (int j = 0; j < 4; j++) begin
                chk("stall_addr", 32'(address), 32'(t_addr[k]));
                chk("stall_idx", 32'(req_index), 32'(k));
                hit_miss  = (j == 3);
                read_data = t_exp[k];
                step();
            end
        end
        hit_miss = 1'b0;
        chk("stall_done", 32'(done), 32'd1);
        chk("stall_count", 32'(stall_cycles), 32'd15);
        chk("stall_timeout", 32'(timeout), 32'd0);

        // Wrong read data on entry 2
        hit_miss = 1'b1;
        do_start(5);
        for (int k = 0; k < 5; k++) begin
            read_data = (k == 2) ? 32'hFAB : t_exp[k];
            step();
        end
        chk("data_done", 32'(done), 32'd1);
        chk("data_mm", 32'(mismatch_count), 32'(exp_mm));

        // start and prog_we during ISSUE are ignored
        hit_miss = 1'b0;
        do_start(3);
        prog_we = 1'b1; prog_idx = 4'd1; prog_addr = 10'h3FF; prog_rw = 1'b0;
        prog_wdata = 32'h5; start = 1'b1; num_req = 5'd1;
        step();
        prog_we = 1'b0; start = 1'b0;
        chk("ign_idx", 32'(req_index), 32'd0);
        chk("ign_busy", 32'(busy), 32'd1);
        hit_miss = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk_req("ign", k);
            read_data = t_exp[k];
            step();
        end
        chk("ign_done", 32'(done), 32'd1);
        chk("ign_stall", 32'(stall_cycles), 32'd1);
        chk("ign_idx_end", 32'(req_index), 32'd2);

        // Reset while request 2 is outstanding
        do_start(5);
        for (int k = 0; k < 2; k++) begin
            read_data = t_exp[k];
            step();
        end
        chk("mid_idx", 32'(req_index), 32'd2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_valid", 32'(req_valid), 32'd0);
        chk("mid_addr", 32'(address), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_done", 32'(done), 32'd0);
        chk("mid_idx0", 32'(req_index), 32'd0);
        step();
        chk("mid_idle", 32'(req_valid), 32'd0);
        do_start(5);
        for (int k = 0; k < 5; k++) begin
            chk_req("restart", k);
            read_data = t_exp[k];
            step();
        end
        chk("restart_done", 32'(done), 32'd1);

        // Zero-length run
        do_start(0);
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_valid", 32'(req_valid), 32'd0);
        chk("zero_busy", 32'(busy), 32'd0);

        // Timeout after 8 stalled cycles on request 0
        hit_miss = 1'b0;
        do_start(5);
        for (int j = 0; j < 8; j++) begin
            chk("to_busy", 32'(busy), 32'd1);
            step();
        end
        chk("to_done", 32'(done), 32'd1);
        chk("to_flag", 32'(timeout), 32'd1);
        chk("to_idx", 32'(req_index), 32'd0);
        chk("to_stall", 32'(stall_cycles), 32'd8);
        step();
        chk("to_valid", 32'(req_valid), 32'd0);
        chk("to_hold", 32'(timeout), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpu_request_sequencer.md
Name: cpu_request_sequencer

Overview:
Parametrised CPU-side request generator for cache labs.
- Replays a programmable table of read/write requests into a cache.
- Advances one entry per cycle in which the cache asserts hit_miss.
- Adds start/done control, per-request timeout and stall statistics; replaces fixed hard-coded request lists in testbenches.
- Sits between a bench (or top-level controller) and the cache's CPU port.

Parameters:
ADDR_WIDTH, 10, width of request address
DATA_WIDTH, 32, width of write/read data
DEPTH, 16, number of request table entries (power of two, >=2)
IDX_WIDTH, $clog2(DEPTH), width of table index and request count
TIMEOUT, 64, max stall cycles per request before abort; 0 disables timeout

Ports:
clock  input  1  system clock, all state updates on posedge
reset  input  1  synchronous, active-high reset
start  input  1  begin a run (accepted in IDLE or DONE only)
num_req  input  IDX_WIDTH+1  requests to replay, latched on accepted start; values >DEPTH treated as DEPTH
prog_we  input  1  table write enable (honoured in IDLE/DONE only)
prog_idx  input  IDX_WIDTH  table entry to write
prog_rw  input  1  entry read_write (0 read, 1 write)
prog_addr  input  ADDR_WIDTH  entry address
prog_wdata  input  DATA_WIDTH  entry write data
prog_expect  input  DATA_WIDTH  entry expected read data (used only with CHECK_READ_DATA_EN)
hit_miss  input  1  cache completion: request done this cycle
read_data  input  DATA_WIDTH  cache read data, valid when hit_miss=1 on a read
req_valid  output  1  request presented on read_write/address/write_data
read_write  output  1  0 read, 1 write
address  output  ADDR_WIDTH  request address
write_data  output  DATA_WIDTH  request write data
req_index  output  IDX_WIDTH  index of current request
busy  output  1  run in progress
done  output  1  run finished; held until next start or reset
timeout  output  1  run aborted by timeout; valid while done=1
stall_cycles  output  16  total cycles with req_valid=1 and hit_miss=0 in this run, saturating at 16'hFFFF
mismatch_count  output  IDX_WIDTH+1  read-data mismatches in this run

Behaviour:
- States: IDLE, ISSUE, DONE.
- Reset (synchronous):
  - State goes to IDLE.
  - busy, done, timeout, req_valid = 0.
  - req_index, stall_cycles, mismatch_count and the per-request stall counter = 0.
  - Table contents are not cleared.
- Request outputs are combinational from table[req_index], gated by req_valid. When req_valid=0, read_write, address and write_data are 0.
- Table writes:
  - Commit at posedge when prog_we=1 and state is IDLE or DONE.
  - Ignored in ISSUE.
  - A write in the same cycle as start is visible to the run.
- Start:
  - start in IDLE or DONE: latch num_req, clear counters, req_index, done and timeout.
  - If the latched count is 0, go to DONE next cycle (done=1, no request issued).
  - Otherwise go to ISSUE.
  - start in ISSUE is ignored.
- ISSUE:
  - req_valid=1 and busy=1.
  - At a posedge with hit_miss=1, the current request completes and the per-request stall counter clears.
    - If req_index == count-1, go to DONE.
    - Otherwise req_index increments.
  - Back-to-back completions give one request per cycle.
  - At a posedge with hit_miss=0: stall_cycles and the per-request counter increment (saturating).
  - If TIMEOUT>0 and the per-request counter reaches TIMEOUT-1 with hit_miss=0, go to DONE with timeout=1.
- hit_miss is ignored outside ISSUE.
- DONE:
  - done=1, busy=0, req_valid=0.
  - req_index holds its last value.
  - Statistics hold until the next accepted start.
- Reset mid-run: abort to IDLE at that edge; no further requests are issued.

Optional Feature:
CHECK_READ_DATA_EN
- Defined:
  - Table stores prog_expect per entry.
  - On each completing read (hit_miss=1, read_write=0), compare read_data to the expected value.
  - On a mismatch, increment mismatch_count (saturating).
  - Writes are never checked.
- Undefined:
  - No expect storage.
  - prog_expect is unused.
  - mismatch_count is tied to 0.

Test Plan:
- Basic replay:
  - Stimulus: program 5 entries (R 0x1A9; W 0x195 data 0xFAC; R 0x195; R 0x154; R 0x195), num_req=5, hit_miss held 1.
  - Response: req_valid high exactly 5 cycles; address sequence as programmed; done=1 on the 6th cycle; stall_cycles=0.
- Stalls:
  - Stimulus: same table; hit_miss low for 3 cycles before each completion.
  - Response: each request held 4 cycles; stall_cycles=15; timeout=0.
- Timeout:
  - Stimulus: TIMEOUT=8, hit_miss tied 0.
  - Response: done=1 and timeout=1 after 8 cycles in ISSUE; req_index=0; req_valid=0 afterwards.
- Edge controls:
  - num_req=0 → done=1 one cycle after start, no req_valid.
  - start or prog_we during ISSUE → ignored (table and run unchanged).
- Reset mid-run:
  - Stimulus: reset at request 2.
  - Response: IDLE next edge; all outputs 0; restart replays from index 0 with the table intact.
- Data check (CHECK_READ_DATA_EN):
  - Stimulus: entry 2 expects 0xFAC, cache returns 0xFAB.
  - Response: mismatch_count=1; with the macro undefined, mismatch_count=0.
